// File: rtl/bg_scroll_ctrl_if.sv
// Bundles the frame-timing and game-control inputs with the scroll outputs of bg_scroll_ctrl.
// Latency: none (wires only).
// Backpressure: none; levels are sampled each pclk and outputs are always valid.
// Signals: vblnk_in, start, pause, game_over, boost (to controller);
//          shift[5:0], speed[2:0], distance[15:0], running, frame_tick (from controller).
interface bg_scroll_ctrl_if;
   logic        vblnk_in;
   logic        start;
   logic        pause;
   logic        game_over;
   logic        boost;
   logic [5:0]  shift;
   logic [2:0]  speed;
   logic [15:0] distance;
   logic        running;
   logic        frame_tick;

   // master drives the game/timing controls and observes the scroll state
   modport master (
      output vblnk_in, start, pause, game_over, boost,
      input  shift, speed, distance, running, frame_tick
   );

   // slave is the scroll controller itself
   modport slave (
      input  vblnk_in, start, pause, game_over, boost,
      output shift, speed, distance, running, frame_tick
   );
endinterface

// File: rtl/bg_scroll_ctrl.sv
// Frame-rate background scroll controller: sequences idle/run/pause/stop, ramps speed, tracks distance.
// Latency: all outputs registered; shift and frame_tick change 1 pclk after vblnk_in rises.
// Backpressure: none; control inputs are levels sampled every pclk, updates only on the frame tick.
// Ports: pclk, rst (async active-high), bus (slave modport: vblnk_in/start/pause/game_over/boost in,
//        shift/speed/distance/running/frame_tick out).
module bg_scroll_ctrl #(
   parameter int START_SPEED = 1,
   parameter int MAX_SPEED   = 4,
   parameter int RAMP_FRAMES = 600,
   parameter int BOOST_STEP  = 2
) (
   input logic             pclk,
   input logic             rst,
   bg_scroll_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSED  = 2'd2,
      S_STOPPED = 2'd3
   } state_t;

   localparam logic [2:0] START_SPD = 3'(START_SPEED);
   localparam logic [2:0] MAX_SPD   = 3'(MAX_SPEED);
   localparam logic [9:0] RAMP_LAST = 10'(RAMP_FRAMES - 1);
   localparam logic [3:0] BOOST_AMT = 4'(BOOST_STEP);

   state_t      state, state_n;
   logic        vblnk_q;
   logic        tick;
   logic [5:0]  shift_r, shift_n;
   logic [2:0]  speed_r, speed_n;
   logic [15:0] dist_r, dist_n;
   logic [9:0]  ramp_cnt, ramp_n;
   logic        running_r;
   logic        frame_tick_r;
   logic [3:0]  step;
   logic [16:0] dist_sum;

   // vblnk_q resets high so a blank already asserted at reset release is not a frame start
   assign tick     = bus.vblnk_in & ~vblnk_q;
   assign step     = {1'b0, speed_r} + (bus.boost ? BOOST_AMT : 4'd0);
   assign dist_sum = {1'b0, dist_r} + 17'(step);

   always_comb begin
      state_n = state;
      shift_n = shift_r;
      speed_n = speed_r;
      dist_n  = dist_r;
      ramp_n  = ramp_cnt;
      case (state)
         S_IDLE: begin
            shift_n = 6'd0;
            speed_n = 3'd0;
            dist_n  = 16'd0;
            ramp_n  = 10'd0;
            if (bus.start) begin
               state_n = S_RUN;
               speed_n = START_SPD;
            end
         end
         S_RUN: begin
            // leaving RUN takes priority over a coincident frame tick
            if (bus.game_over) begin
               state_n = S_STOPPED;
            end else if (bus.pause) begin
               state_n = S_PAUSED;
            end else if (tick) begin
               shift_n = shift_r - 6'(step);
               dist_n  = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
               if (ramp_cnt == RAMP_LAST) begin
                  ramp_n  = 10'd0;
                  speed_n = (speed_r < MAX_SPD) ? speed_r + 3'd1 : MAX_SPD;
               end else begin
                  ramp_n = ramp_cnt + 10'd1;
               end
            end
         end
         S_PAUSED: begin
            if (bus.game_over) begin
               state_n = S_STOPPED;
            end else if (!bus.pause) begin
               state_n = S_RUN;
            end
         end
         S_STOPPED: begin
            // values are cleared by the IDLE state on the following edge
            if (bus.start) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         vblnk_q      <= 1'b1;
         shift_r      <= 6'd0;
         speed_r      <= 3'd0;
         dist_r       <= 16'd0;
         ramp_cnt     <= 10'd0;
         running_r    <= 1'b0;
         frame_tick_r <= 1'b0;
      end else begin
         state        <= state_n;
         vblnk_q      <= bus.vblnk_in;
         shift_r      <= shift_n;
         speed_r      <= speed_n;
         dist_r       <= dist_n;
         ramp_cnt     <= ramp_n;
         running_r    <= (state_n == S_RUN);
         frame_tick_r <= tick;
      end
   end

   assign bus.shift      = shift_r;
   assign bus.speed      = speed_r;
   assign bus.distance   = dist_r;
   assign bus.running    = running_r;
   assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Directed bench for bg_scroll_ctrl: dut_a uses default parameters, dut_b a fast ramp
// (RAMP_FRAMES=4, MAX_SPEED=3). Both share vblnk/pause/game_over/boost; start is per DUT.
// Inputs change on negedge pclk, outputs are sampled on negedge pclk.
module tb_bg_scroll_ctrl;

   logic pclk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   ft_a;
   int   ft_b;
   int   f0;

   bg_scroll_ctrl_if ifa ();
   bg_scroll_ctrl_if ifb ();

   bg_scroll_ctrl dut_a (
      .pclk (pclk),
      .rst  (rst),
      .bus  (ifa)
   );

   bg_scroll_ctrl #(
      .MAX_SPEED   (3),
      .RAMP_FRAMES (4)
   ) dut_b (
      .pclk (pclk),
      .rst  (rst),
      .bus  (ifb)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(negedge pclk) begin
      if (ifa.frame_tick === 1'b1) ft_a++;
      if (ifb.frame_tick === 1'b1) ft_b++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_vblnk(input logic v);
      ifa.vblnk_in = v;
      ifb.vblnk_in = v;
   endtask

   task automatic set_ctl(input logic p, input logic g, input logic b);
      ifa.pause     = p;
      ifb.pause     = p;
      ifa.game_over = g;
      ifb.game_over = g;
      ifa.boost     = b;
      ifb.boost     = b;
   endtask

   // raise blank; returns at the negedge just after the tick edge
   task automatic vrise();
      @(negedge pclk);
      set_vblnk(1'b1);
      @(negedge pclk);
   endtask

   task automatic vfall();
      set_vblnk(1'b0);
      @(negedge pclk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      ft_a  = 0;
      ft_b  = 0;
      rst   = 1'b1;
      set_vblnk(1'b0);
      set_ctl(1'b0, 1'b0, 1'b0);
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      repeat (3) @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);

      // reset state
      chk("rst_shift", 32'(ifa.shift), 0);
      chk("rst_speed", 32'(ifa.speed), 0);
      chk("rst_dist", 32'(ifa.distance), 0);
      chk("rst_running", 32'(ifa.running), 0);
      chk("rst_ftick", 32'(ifa.frame_tick), 0);

      // 1: ticks while idle
      vrise();
      chk("t1_ftick_hi", 32'(ifa.frame_tick), 1);
      vfall();
      chk("t1_ftick_lo", 32'(ifa.frame_tick), 0);
      repeat (2) begin vrise(); vfall(); end
      chk("t1_ft_count_a", 32'(ft_a), 3);
      chk("t1_ft_count_b", 32'(ft_b), 3);
      chk("t1_shift", 32'(ifa.shift), 0);
      chk("t1_speed", 32'(ifa.speed), 0);
      chk("t1_running", 32'(ifa.running), 0);

      // 3: speed ramp on dut_b
      @(negedge pclk);
      ifb.start = 1'b1;
      @(negedge pclk);
      ifb.start = 1'b0;
      chk("t3_running", 32'(ifb.running), 1);
      chk("t3_speed0", 32'(ifb.speed), 1);
      for (int i = 1; i <= 12; i++) begin
         vrise();
         if (i == 3)  chk("t3_speed_t3", 32'(ifb.speed), 1);
         if (i == 4)  chk("t3_speed_t4", 32'(ifb.speed), 2);
         if (i == 8)  chk("t3_speed_t8", 32'(ifb.speed), 3);
         if (i == 12) chk("t3_speed_t12", 32'(ifb.speed), 3);
         vfall();
      end
      chk("t3_dist", 32'(ifb.distance), 24);
      chk("t3_shift", 32'(ifb.shift), 40);
      chk("t3_a_idle_shift", 32'(ifa.shift), 0);
      set_ctl(1'b0, 1'b1, 1'b0);
      @(negedge pclk);
      set_ctl(1'b0, 1'b0, 1'b0);
      chk("t3_b_stopped", 32'(ifb.running), 0);

      // 2: start dut_a, three frames
      ifa.start = 1'b1;
      @(negedge pclk);
      ifa.start = 1'b0;
      chk("t2_speed", 32'(ifa.speed), 1);
      chk("t2_shift0", 32'(ifa.shift), 0);
      vrise(); chk("t2_shift_f1", 32'(ifa.shift), 63); vfall();
      vrise(); chk("t2_shift_f2", 32'(ifa.shift), 62); vfall();
      vrise(); chk("t2_shift_f3", 32'(ifa.shift), 61); vfall();
      chk("t2_dist", 32'(ifa.distance), 3);

      // 4: reach shift=1, then boost wraps
      repeat (60) begin vrise(); vfall(); end
      chk("t4_shift_pre", 32'(ifa.shift), 1);
      chk("t4_dist_pre", 32'(ifa.distance), 63);
      set_ctl(1'b0, 1'b0, 1'b1);
      vrise();
      chk("t4_boost_shift", 32'(ifa.shift), 62);
      chk("t4_boost_dist", 32'(ifa.distance), 66);
      set_ctl(1'b0, 1'b0, 1'b0);
      vfall();
      vrise();
      chk("t4_noboost_shift", 32'(ifa.shift), 61);
      chk("t4_noboost_dist", 32'(ifa.distance), 67);
      vfall();

      // 5: pause, game_over on a tick, restart
      set_ctl(1'b1, 1'b0, 1'b0);
      @(negedge pclk);
      chk("t5_paused_running", 32'(ifa.running), 0);
      f0 = ft_a;
      repeat (2) begin vrise(); vfall(); end
      chk("t5_paused_shift", 32'(ifa.shift), 61);
      chk("t5_paused_dist", 32'(ifa.distance), 67);
      chk("t5_paused_ramp", 32'(dut_a.ramp_cnt), 65);
      chk("t5_paused_ticks", 32'(ft_a - f0), 2);
      set_ctl(1'b0, 1'b0, 1'b0);
      @(negedge pclk);
      chk("t5_resume_running", 32'(ifa.running), 1);
      set_ctl(1'b0, 1'b1, 1'b0);
      set_vblnk(1'b1);
      @(negedge pclk);
      chk("t5_go_ftick", 32'(ifa.frame_tick), 1);
      chk("t5_go_running", 32'(ifa.running), 0);
      chk("t5_go_shift", 32'(ifa.shift), 61);
      chk("t5_go_dist", 32'(ifa.distance), 67);
      set_ctl(1'b0, 1'b0, 1'b0);
      vfall();
      ifa.start = 1'b1;
      @(negedge pclk);
      chk("t5_idle_running", 32'(ifa.running), 0);
      @(negedge pclk);
      ifa.start = 1'b0;
      chk("t5_rerun_running", 32'(ifa.running), 1);
      chk("t5_rerun_shift", 32'(ifa.shift), 0);
      chk("t5_rerun_dist", 32'(ifa.distance), 0);
      chk("t5_rerun_speed", 32'(ifa.speed), 1);
      chk("t5_b_frozen_dist", 32'(ifb.distance), 24);
      chk("t5_b_frozen_shift", 32'(ifb.shift), 40);
      chk("t5_b_frozen_speed", 32'(ifb.speed), 3);

      // 6: async reset mid-frame
      repeat (24) begin vrise(); vfall(); end
      chk("t6_shift_pre", 32'(ifa.shift), 40);
      chk("t6_dist_pre", 32'(ifa.distance), 24);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_shift", 32'(ifa.shift), 0);
      chk("t6_rst_speed", 32'(ifa.speed), 0);
      chk("t6_rst_dist", 32'(ifa.distance), 0);
      chk("t6_rst_running", 32'(ifa.running), 0);
      chk("t6_rst_ftick", 32'(ifa.frame_tick), 0);
      set_vblnk(1'b1);
      @(negedge pclk);
      rst = 1'b0;
      f0 = ft_a;
      repeat (4) @(negedge pclk);
      chk("t6_no_tick", 32'(ft_a - f0), 0);
      vfall();
      vrise();
      chk("t6_real_tick", 32'(ifa.frame_tick), 1);
      vfall();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
